led_peripheral: RTL and testbench

- Memory-mapped LED output stage directly downstream of the cpu core; consumes the core's load/store requests to a small register window and drives the board's 6 LEDs.
- Supports three modes: static pattern, blink at a programmable half-period, and global PWM dimming.
- Replaces the core's direct led wiring; `led` is registered and glitch-free.

---
 rtl/led_peripheral_pkg.sv | 27 ++
 rtl/led_peripheral_if.sv | 21 ++
 rtl/led_peripheral_pwm_timer.sv | 56 +++++
 rtl/led_peripheral.sv | 125 ++++++++++++
 tb/tb_led_peripheral.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/led_peripheral_pkg.sv
// Shared definitions for the LED output stage: register window offsets,
// mode encodings and the base address the core decodes to reach it.
package led_peripheral_pkg;

  localparam logic [3:0] LED_REG_PATTERN = 4'h0;
  localparam logic [3:0] LED_REG_MODE    = 4'h4;
  localparam logic [3:0] LED_REG_PERIOD  = 4'h8;
  localparam logic [3:0] LED_REG_DUTY    = 4'hC;

  localparam logic [31:0] LED_BASE_ADDR = 32'h4000_0000;

  typedef enum logic [1:0] {
    LED_MODE_STATIC    = 2'd0,
    LED_MODE_BLINK     = 2'd1,
    LED_MODE_PWM       = 2'd2,
    LED_MODE_BLINK_PWM = 2'd3
  } led_mode_e;

  function automatic logic mode_uses_blink(input led_mode_e mode);
    return (mode == LED_MODE_BLINK) || (mode == LED_MODE_BLINK_PWM);
  endfunction

  function automatic logic mode_uses_pwm(input led_mode_e mode);
    return (mode == LED_MODE_PWM) || (mode == LED_MODE_BLINK_PWM);
  endfunction

endpackage

// File: rtl/led_peripheral_if.sv
// Core-to-peripheral request/response bus. valid/ready semantics: a request is
// taken on every edge where req_valid=1 (no ready, never stalls); resp_ack pulses
// exactly one cycle later and resp_rdata is meaningful only while resp_ack=1.
interface led_peripheral_if;
  logic        req_valid;
  logic        req_write;
  logic [3:0]  req_address;
  logic [31:0] req_wdata;
  logic        resp_ack;
  logic [31:0] resp_rdata;

  modport master (
    output req_valid, req_write, req_address, req_wdata,
    input  resp_ack, resp_rdata
  );

  modport slave (
    input  req_valid, req_write, req_address, req_wdata,
    output resp_ack, resp_rdata
  );
endinterface

// File: rtl/led_peripheral_pwm_timer.sv
// Blink half-period counter with phase, plus free-running PWM counter/compare.
// Both restart together on clear so blink and PWM stay aligned after a reconfigure.
module led_pwm_timer #(
  parameter int BLINK_BITS = 24,
  parameter int PWM_BITS   = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clear,
  input  logic [BLINK_BITS-1:0] period,
  input  logic [PWM_BITS-1:0]   duty,
  output logic                  phase,
  output logic                  pwm_on
);

  localparam logic [BLINK_BITS-1:0] BLINK_ONE = {{(BLINK_BITS-1){1'b0}}, 1'b1};
  localparam logic [PWM_BITS-1:0]   PWM_ONE   = {{(PWM_BITS-1){1'b0}}, 1'b1};

  logic [BLINK_BITS-1:0] blink_cnt_q, blink_cnt_d;
  logic                  phase_q, phase_d;
  logic [PWM_BITS-1:0]   pwm_cnt_q, pwm_cnt_d;

  always_comb begin
    blink_cnt_d = blink_cnt_q + BLINK_ONE;
    phase_d     = phase_q;
    pwm_cnt_d   = pwm_cnt_q + PWM_ONE;
    if (clear) begin
      blink_cnt_d = '0;
      phase_d     = 1'b1;
      pwm_cnt_d   = '0;
    end else if (period <= BLINK_ONE) begin
      // Period 0/1 means steady on rather than toggling every cycle.
      blink_cnt_d = '0;
      phase_d     = 1'b1;
    end else if (blink_cnt_q == period - BLINK_ONE) begin
      blink_cnt_d = '0;
      phase_d     = ~phase_q;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      blink_cnt_q <= '0;
      phase_q     <= 1'b1;
      pwm_cnt_q   <= '0;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      pwm_cnt_q   <= pwm_cnt_d;
    end
  end

  assign phase  = phase_q;
  assign pwm_on = (pwm_cnt_q < duty);

endmodule

// File: rtl/led_peripheral.sv
// Memory-mapped LED driver: four-register window (pattern/mode/period/duty),
// single-cycle ack for every request, registered glitch-free LED output.
module led_peripheral
  import led_peripheral_pkg::*;
#(
  parameter int LED_WIDTH  = 6,
  parameter int BLINK_BITS = 24,
  parameter int PWM_BITS   = 8,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic                 clock,
  input  logic                 reset,
  led_peripheral_if.slave      bus,
  output logic [LED_WIDTH-1:0] led
);

  localparam logic [LED_WIDTH-1:0] LED_OFF = ACTIVE_LOW ? {LED_WIDTH{1'b1}} : {LED_WIDTH{1'b0}};

  logic [LED_WIDTH-1:0]  pattern_q, pattern_d;
  led_mode_e             mode_q, mode_d;
  logic [BLINK_BITS-1:0] period_q, period_d;
  logic [PWM_BITS-1:0]   duty_q, duty_d;
  logic                  resp_ack_q, resp_ack_d;
  logic [31:0]           resp_rdata_q, resp_rdata_d;
  logic [LED_WIDTH-1:0]  led_q, led_d;

  logic [3:0]            reg_off;
  logic [31:0]           rd_word;
  logic                  wr_en;
  logic                  timer_clear;
  logic                  phase;
  logic                  pwm_on;
  logic                  lit_gate;
  logic [LED_WIDTH-1:0]  lit_mask;
  logic                  unused_bits;

  // Byte-lane bits and store-data bits above each register's width are dropped.
  assign unused_bits = ^{bus.req_address[1:0], bus.req_wdata};

  assign reg_off = {bus.req_address[3:2], 2'b00};
  assign wr_en   = bus.req_valid && bus.req_write;

  always_comb begin
    rd_word = '0;
    case (reg_off)
      LED_REG_PATTERN: rd_word[LED_WIDTH-1:0]  = pattern_q;
      LED_REG_MODE:    rd_word[1:0]            = mode_q;
      LED_REG_PERIOD:  rd_word[BLINK_BITS-1:0] = period_q;
      LED_REG_DUTY:    rd_word[PWM_BITS-1:0]   = duty_q;
      default:         rd_word                 = '0;
    endcase
  end

  always_comb begin
    pattern_d   = pattern_q;
    mode_d      = mode_q;
    period_d    = period_q;
    duty_d      = duty_q;
    timer_clear = 1'b0;
    if (wr_en) begin
      case (reg_off)
        LED_REG_PATTERN: pattern_d = bus.req_wdata[LED_WIDTH-1:0];
        LED_REG_MODE: begin
          mode_d      = led_mode_e'(bus.req_wdata[1:0]);
          timer_clear = 1'b1;
        end
        LED_REG_PERIOD: begin
          period_d    = bus.req_wdata[BLINK_BITS-1:0];
          timer_clear = 1'b1;
        end
        LED_REG_DUTY:    duty_d = bus.req_wdata[PWM_BITS-1:0];
        default: ;
      endcase
    end
  end

  always_comb begin
    resp_ack_d   = bus.req_valid;
    resp_rdata_d = (bus.req_valid && !bus.req_write) ? rd_word : '0;
  end

  led_pwm_timer #(
    .BLINK_BITS (BLINK_BITS),
    .PWM_BITS   (PWM_BITS)
  ) u_timer (
    .clock  (clock),
    .reset  (reset),
    .clear  (timer_clear),
    .period (period_q),
    .duty   (duty_q),
    .phase  (phase),
    .pwm_on (pwm_on)
  );

  always_comb begin
    lit_gate = (!mode_uses_blink(mode_q) || phase) && (!mode_uses_pwm(mode_q) || pwm_on);
    lit_mask = pattern_q & {LED_WIDTH{lit_gate}};
    led_d    = ACTIVE_LOW ? ~lit_mask : lit_mask;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pattern_q    <= '0;
      mode_q       <= LED_MODE_STATIC;
      period_q     <= '0;
      duty_q       <= '0;
      resp_ack_q   <= 1'b0;
      resp_rdata_q <= '0;
      led_q        <= LED_OFF;
    end else begin
      pattern_q    <= pattern_d;
      mode_q       <= mode_d;
      period_q     <= period_d;
      duty_q       <= duty_d;
      resp_ack_q   <= resp_ack_d;
      resp_rdata_q <= resp_rdata_d;
      led_q        <= led_d;
    end
  end

  assign bus.resp_ack   = resp_ack_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign led            = led_q;

endmodule

// File: tb/tb_led_peripheral.sv
// Directed and randomized bench for led_peripheral against a cycle-count based
// reference: blink phase and PWM level derived from cycles since the last clear.
module tb_led_peripheral;

  logic       clock;
  logic       reset;
  logic [5:0] led;

  led_peripheral_if bus ();

  led_peripheral dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus),
    .led   (led)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int checks   = 0;
  int failures = 0;

  // Reference model state
  int unsigned m_pattern = 0;
  int unsigned m_mode    = 0;
  int unsigned m_period  = 0;
  int unsigned m_duty    = 0;
  int          edge_n    = 0;
  int          clr_edge  = 0;
  int          k;
  bit          m_phase;
  bit          m_pwm;
  int unsigned m_lit;
  int unsigned m_rd;
  logic [5:0]  exp_led   = 6'h3F;
  logic        exp_ack   = 1'b0;
  logic [31:0] exp_rdata = 32'h0;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_pattern = 0; m_mode = 0; m_period = 0; m_duty = 0;
      clr_edge  = edge_n;
      exp_led   = 6'h3F;
      exp_ack   = 1'b0;
      exp_rdata = 32'h0;
    end else begin
      edge_n++;
      k       = edge_n - 1 - clr_edge;
      m_phase = (m_period <= 1) ? 1'b1 : (((k / m_period) % 2) == 0);
      m_pwm   = (k % 256) < m_duty;
      case (m_mode)
        0:       m_lit = m_pattern;
        1:       m_lit = m_phase ? m_pattern : 0;
        2:       m_lit = m_pwm ? m_pattern : 0;
        default: m_lit = (m_phase && m_pwm) ? m_pattern : 0;
      endcase
      exp_led = ~m_lit[5:0];
      exp_ack = bus.req_valid;
      m_rd = 0;
      if (bus.req_valid && !bus.req_write) begin
        case (bus.req_address / 4)
          0: m_rd = m_pattern;
          1: m_rd = m_mode;
          2: m_rd = m_period;
          default: m_rd = m_duty;
        endcase
      end
      exp_rdata = m_rd;
      if (bus.req_valid && bus.req_write) begin
        case (bus.req_address / 4)
          0: m_pattern = bus.req_wdata % 64;
          1: begin m_mode = bus.req_wdata % 4; clr_edge = edge_n; end
          2: begin m_period = bus.req_wdata % (1 << 24); clr_edge = edge_n; end
          default: m_duty = bus.req_wdata % 256;
        endcase
      end
    end
  end

  task automatic check_outputs(input string tag);
    checks++;
    assert (led === exp_led) else begin
      failures++;
      $error("FAIL %s led got=%b exp=%b", tag, led, exp_led);
    end
    checks++;
    assert (bus.resp_ack === exp_ack) else begin
      failures++;
      $error("FAIL %s resp_ack got=%b exp=%b", tag, bus.resp_ack, exp_ack);
    end
    checks++;
    assert (bus.resp_rdata === exp_rdata) else begin
      failures++;
      $error("FAIL %s resp_rdata got=%h exp=%h", tag, bus.resp_rdata, exp_rdata);
    end
  endtask

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Called at a falling edge: presents one request, then checks after the next rising edge.
  task automatic bus_cycle(input logic v, input logic w, input logic [3:0] a,
                           input logic [31:0] d, input string tag);
    bus.req_valid   = v;
    bus.req_write   = w;
    bus.req_address = a;
    bus.req_wdata   = d;
    @(negedge clock);
    check_outputs(tag);
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) bus_cycle(1'b0, 1'b0, 4'h0, 32'h0, tag);
  endtask

  task automatic read_all_zero(input string tag);
    for (int r = 0; r < 4; r++) begin
      bus_cycle(1'b1, 1'b0, 4'(r * 4), 32'h0, tag);
      check_value({tag, "_ack"}, {31'h0, bus.resp_ack}, 32'h1);
      check_value({tag, "_rdata"}, bus.resp_rdata, 32'h0);
    end
  endtask

  task automatic pwm_count(input logic [31:0] duty, input string tag);
    int lit_cnt;
    bus_cycle(1'b1, 1'b1, 4'hC, duty, tag);
    idle(3, tag);
    lit_cnt = 0;
    for (int i = 0; i < 256; i++) begin
      idle(1, tag);
      if (led === 6'b000000) lit_cnt++;
    end
    check_value({tag, "_lit_count"}, lit_cnt, duty);
  endtask

  initial begin
    reset           = 1'b1;
    bus.req_valid   = 1'b0;
    bus.req_write   = 1'b0;
    bus.req_address = 4'h0;
    bus.req_wdata   = 32'h0;
    repeat (2) @(negedge clock);
    reset = 1'b0;

    // Reset state and reads of all four registers
    idle(2, "reset_idle");
    check_value("reset_led", {26'h0, led}, 32'h3F);
    read_all_zero("reset_read");

    // Static pattern write and readback
    bus_cycle(1'b1, 1'b1, 4'h0, 32'h2A, "wr_pattern");
    idle(1, "pattern_vis");
    check_value("pattern_led", {26'h0, led}, 32'h15);
    bus_cycle(1'b1, 1'b0, 4'h0, 32'h0, "rd_pattern");
    check_value("rd_pattern_val", bus.resp_rdata, 32'h2A);

    // Blink with period 4, then restart mid-period via a MODE rewrite
    bus_cycle(1'b1, 1'b1, 4'h8, 32'd4, "wr_period");
    bus_cycle(1'b1, 1'b1, 4'h4, 32'd1, "wr_mode_blink");
    idle(14, "blink_run");
    bus_cycle(1'b1, 1'b1, 4'h4, 32'd1, "rewr_mode");
    for (int i = 0; i < 4; i++) begin
      idle(1, "blink_restart_on");
      check_value("blink_restart_on_led", {26'h0, led}, 32'h15);
    end
    idle(1, "blink_restart_off");
    check_value("blink_restart_off_led", {26'h0, led}, 32'h3F);
    idle(8, "blink_tail");

    // PWM dimming at three duty settings
    bus_cycle(1'b1, 1'b1, 4'h0, 32'h3F, "wr_pattern_full");
    bus_cycle(1'b1, 1'b1, 4'h4, 32'd2, "wr_mode_pwm");
    pwm_count(32'd64, "pwm64");
    pwm_count(32'd0, "pwm0");
    pwm_count(32'd255, "pwm255");

    // Aliased offsets, masked write data, back-to-back requests
    bus_cycle(1'b1, 1'b0, 4'h3, 32'h0, "rd_alias");
    check_value("rd_alias_val", bus.resp_rdata, 32'h3F);
    bus_cycle(1'b1, 1'b1, 4'h5, 32'hFFFF_FFF0, "wr_mode_masked");
    bus_cycle(1'b1, 1'b0, 4'h4, 32'h0, "b2b_0");
    check_value("rd_mode_masked", bus.resp_rdata, 32'h0);
    bus_cycle(1'b1, 1'b0, 4'hF, 32'h0, "b2b_1");
    check_value("b2b_1_ack", {31'h0, bus.resp_ack}, 32'h1);
    bus_cycle(1'b1, 1'b1, 4'h0, 32'h0C, "b2b_2");
    check_value("b2b_2_ack", {31'h0, bus.resp_ack}, 32'h1);
    idle(1, "b2b_done");

    // Randomized traffic; keep periods short so blinking is exercised
    for (int i = 0; i < 300; i++) begin
      logic [3:0]  a;
      logic [31:0] d;
      a = 4'($urandom_range(0, 15));
      d = (a[3:2] == 2'd2) ? 32'($urandom_range(0, 7)) : $urandom;
      bus_cycle($urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1, a, d, "random");
    end

    // Asynchronous reset between edges while blinking
    bus_cycle(1'b1, 1'b1, 4'h0, 32'h3F, "ar_pattern");
    bus_cycle(1'b1, 1'b1, 4'h8, 32'd3, "ar_period");
    bus_cycle(1'b1, 1'b1, 4'h4, 32'd1, "ar_mode");
    bus_cycle(1'b1, 1'b0, 4'h8, 32'h0, "ar_read");
    @(posedge clock);
    #2 reset = 1'b1;
    #1;
    check_outputs("async_reset");
    check_value("async_reset_led", {26'h0, led}, 32'h3F);
    check_value("async_reset_ack", {31'h0, bus.resp_ack}, 32'h0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    idle(2, "post_reset_idle");
    read_all_zero("post_reset_read");
    bus_cycle(1'b1, 1'b1, 4'h0, 32'h2A, "post_reset_wr");
    idle(1, "post_reset_vis");
    check_value("post_reset_led", {26'h0, led}, 32'h15);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
